// File: rtl/uar_frame_rx.sv
// UART frame receiver: oversampled, majority-voted bytes packed into a wide frame
// that closes on an idle gap or when full, handed off over valid/ready.
module uar_frame_rx #(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned BAUD_RATE    = 9600,
  parameter int unsigned SAMP_PER_BIT = 16,
  parameter int unsigned MAX_BYTES    = 21,
  parameter int unsigned IDLE_CLKS    = 200_000
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           sig_in,
  output logic [8*MAX_BYTES-1:0]         data_out,
  output logic [$clog2(MAX_BYTES+1)-1:0] frame_bytes,
  output logic                           frame_valid,
  input  logic                           frame_ready,
  output logic                           frame_err,
  output logic                           overrun,
  output logic                           busy
);

  localparam int unsigned CLK_PER_SAMP = CLK_HZ / BAUD_RATE / SAMP_PER_BIT;
  localparam int unsigned FBW = $clog2(MAX_BYTES + 1);
  localparam int unsigned SCW = (CLK_PER_SAMP > 1) ? $clog2(CLK_PER_SAMP) : 1;
  localparam int unsigned TCW = $clog2(SAMP_PER_BIT);
  localparam int unsigned M   = SAMP_PER_BIT / 2;
  localparam int unsigned IDW = ($clog2(IDLE_CLKS + 1) > 32) ? $clog2(IDLE_CLKS + 1) : 32;
  localparam logic [FBW-1:0] LAST_IDX = FBW'(MAX_BYTES - 1);

  typedef enum logic [2:0] {IDLE_WAIT, ARMED, START, DATA, STOP} state_t;

  state_t state, state_nx;

  logic                   sync_m, sync, sync_d;
  logic [SCW-1:0]         samp_cnt;
  logic [TCW-1:0]         tick_cnt;
  logic [IDW-1:0]         idle_cnt;
  logic                   v0, v1;
  logic [7:0]             shreg;
  logic [2:0]             bit_cnt;
  logic [8*MAX_BYTES-1:0] asm_buf;
  logic [FBW-1:0]         byte_cnt;
  logic                   close_pend;

  logic fall, tick, in_bit, vote_ev, vote, idle_done;
  logic stop_ok, stop_bad, arm_now, close_gap, close_full;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_m <= 1'b1;
      sync   <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      sync_m <= sig_in;
      sync   <= sync_m;
      sync_d <= sync;
    end
  end

  // Vote is resolved on the tick that takes sample M+1; M-1 and M are held in v0/v1.
  assign fall      = sync_d & ~sync;
  assign tick      = (samp_cnt == SCW'(CLK_PER_SAMP - 1));
  assign in_bit    = (state == START) || (state == DATA) || (state == STOP);
  assign vote_ev   = in_bit && tick && (tick_cnt == TCW'(M));
  assign vote      = (v0 & v1) | (v0 & sync) | (v1 & sync);
  assign idle_done = sync && (idle_cnt >= IDW'(IDLE_CLKS - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE_WAIT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE_WAIT: if (idle_done) state_nx = ARMED;
      ARMED:     if (fall) state_nx = START;
      START:     if (vote_ev) state_nx = vote ? ARMED : DATA;
      DATA:      if (vote_ev && bit_cnt == 3'd7) state_nx = STOP;
      STOP:      if (vote_ev) state_nx = vote ? ARMED : IDLE_WAIT;
      default:   state_nx = IDLE_WAIT;
    endcase
  end

  always_comb begin
    busy       = in_bit;
    stop_ok    = (state == STOP) && vote_ev && vote;
    stop_bad   = (state == STOP) && vote_ev && !vote;
    arm_now    = (state == IDLE_WAIT) && idle_done;
    close_gap  = (state == ARMED) && !fall && (byte_cnt != '0) && idle_done && !close_pend;
    close_full = stop_ok && (byte_cnt == LAST_IDX);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      samp_cnt <= '0;
      tick_cnt <= '0;
    end else if (state == ARMED && fall) begin
      samp_cnt <= '0;
      tick_cnt <= '0;
    end else begin
      samp_cnt <= tick ? '0 : samp_cnt + 1'b1;
      if (tick && in_bit)
        tick_cnt <= (tick_cnt == TCW'(SAMP_PER_BIT - 1)) ? '0 : tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      idle_cnt    <= '0;
      v0          <= 1'b0;
      v1          <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      asm_buf     <= '0;
      byte_cnt    <= '0;
      close_pend  <= 1'b0;
      data_out    <= '0;
      frame_bytes <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      close_pend <= close_gap | close_full;

      if (!sync || in_bit || arm_now || close_gap) idle_cnt <= '0;
      else if (idle_cnt != '1)                     idle_cnt <= idle_cnt + 1'b1;

      if (tick && tick_cnt == TCW'(M - 2)) v0 <= sync;
      if (tick && tick_cnt == TCW'(M - 1)) v1 <= sync;

      if (state == START) bit_cnt <= '0;
      if (vote_ev && state == DATA) begin
        shreg   <= {vote, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (stop_ok) begin
        for (int unsigned k = 0; k < MAX_BYTES; k++)
          if (byte_cnt == FBW'(k)) asm_buf[8*k +: 8] <= shreg;
        byte_cnt <= byte_cnt + 1'b1;
      end
      if (stop_bad) begin
        frame_err <= 1'b1;
        asm_buf   <= '0;
        byte_cnt  <= '0;
      end

      // A closing frame either replaces the output (free or accepted this cycle) or is dropped.
      if (close_pend) begin
        asm_buf  <= '0;
        byte_cnt <= '0;
        if (frame_valid && !frame_ready) begin
          overrun <= 1'b1;
        end else begin
          data_out    <= asm_buf;
          frame_bytes <= byte_cnt;
          frame_valid <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uar_frame_rx.sv
// Scoreboard bench for uar_frame_rx: 10 clk/sample, 160 clk/bit, 4-byte frames, 2000-clk idle gap.
module tb_uar_frame_rx;

  localparam int K_DATA = 0, K_BYTES = 1, K_VALID = 2, K_BUSY = 3, K_ERRP = 4,
                 K_OVRP = 5, K_ERRCNT = 6, K_OVRCNT = 7, K_POPS = 8, K_SBSIZE = 9;
  localparam int BIT = 160;

  logic        clk = 1'b0;
  logic        rst, sig, ready;
  logic [31:0] data_out;
  logic [2:0]  frame_bytes;
  logic        frame_valid, frame_err, overrun, busy;

  typedef struct { logic [31:0] data; logic [2:0] nb; } frame_t;
  typedef struct { string name; int kind; logic [31:0] exp; } chk_t;

  frame_t sb[$];
  chk_t   cq[$];
  int n_checks = 0, n_fail = 0, err_seen = 0, ovr_seen = 0, pops = 0;

  always #5 clk = ~clk;

  uar_frame_rx #(
    .CLK_HZ(1_600_000), .BAUD_RATE(10_000), .SAMP_PER_BIT(16),
    .MAX_BYTES(4), .IDLE_CLKS(2000)
  ) dut (
    .clk_in(clk), .rst_in(rst), .sig_in(sig), .data_out(data_out),
    .frame_bytes(frame_bytes), .frame_valid(frame_valid), .frame_ready(ready),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  // Monitor: owns all counters; pops frames on handshake and serves stimulus check requests.
  initial begin
    logic        prev_hold;
    logic [31:0] prev_data;
    logic [2:0]  prev_nb;
    frame_t      e;
    chk_t        c;
    logic [31:0] act;
    prev_hold = 1'b0;
    prev_data = '0;
    prev_nb   = '0;
    forever begin
      @(negedge clk);
      if (frame_err) err_seen++;
      if (overrun)   ovr_seen++;
      if (prev_hold && !rst) begin
        n_checks++;
        if (!frame_valid || data_out !== prev_data || frame_bytes !== prev_nb) begin
          n_fail++;
          $display("FAIL hold_stable: got valid=%0b data=%h bytes=%0d, need valid=1 data=%h bytes=%0d",
                   frame_valid, data_out, frame_bytes, prev_data, prev_nb);
        end
      end
      prev_hold = frame_valid && !ready && !rst;
      prev_data = data_out;
      prev_nb   = frame_bytes;
      if (frame_valid && ready && !rst) begin
        pops++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_frame: got data=%h bytes=%0d, need no frame", data_out, frame_bytes);
        end else begin
          e = sb.pop_front();
          if (data_out !== e.data || frame_bytes !== e.nb) begin
            n_fail++;
            $display("FAIL frame: got data=%h bytes=%0d, need data=%h bytes=%0d",
                     data_out, frame_bytes, e.data, e.nb);
          end
        end
      end
      while (cq.size() != 0) begin
        c = cq.pop_front();
        case (c.kind)
          K_DATA:   act = data_out;
          K_BYTES:  act = 32'(frame_bytes);
          K_VALID:  act = 32'(frame_valid);
          K_BUSY:   act = 32'(busy);
          K_ERRP:   act = 32'(frame_err);
          K_OVRP:   act = 32'(overrun);
          K_ERRCNT: act = 32'(err_seen);
          K_OVRCNT: act = 32'(ovr_seen);
          K_POPS:   act = 32'(pops);
          default:  act = 32'(sb.size());
        endcase
        n_checks++;
        if (act !== c.exp) begin
          n_fail++;
          $display("FAIL %s: got %h, need %h", c.name, act, c.exp);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int kind, input logic [31:0] exp);
    chk_t c;
    c.name = name; c.kind = kind; c.exp = exp;
    cq.push_back(c);
  endtask

  task automatic expect_frame(input logic [31:0] d, input logic [2:0] n);
    frame_t f;
    f.data = d; f.nb = n;
    sb.push_back(f);
  endtask

  task automatic line(input logic v, input int n);
    sig = v;
    cyc(n);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    line(1'b0, BIT);
    for (int i = 0; i < 8; i++) line(b[i], BIT);
    line(stop, BIT);
  endtask

  task automatic drain(input string name, input int max_cyc);
    int i;
    i = 0;
    while (sb.size() != 0 && i < max_cyc) begin
      cyc(1);
      i++;
    end
    chk(name, K_SBSIZE, 32'd0);
    cyc(2);
  endtask

  initial begin
    rst = 1'b1; sig = 1'b1; ready = 1'b1;
    cyc(5);
    chk("rst_valid", K_VALID, 0); chk("rst_data", K_DATA, 0); chk("rst_bytes", K_BYTES, 0);
    chk("rst_err", K_ERRP, 0);    chk("rst_ovr", K_OVRP, 0);  chk("rst_busy", K_BUSY, 0);
    cyc(2);
    rst = 1'b0;

    // 1: single byte closed by idle gap
    line(1'b1, 2100);
    expect_frame(32'h0000_00A5, 3'd1);
    send_byte(8'hA5, 1'b1);
    line(1'b1, 2100);
    drain("t1_drain", 3000);
    chk("t1_pops", K_POPS, 1);

    // 2: full frame closes right after the 4th stop bit
    expect_frame(32'h4433_2211, 3'd4);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    chk("t2_no_gap_close", K_POPS, 2);
    drain("t2_drain", 200);
    chk("t2_err", K_ERRCNT, 0);

    // 3: bad stop bit discards partial frame; bytes before re-arm are ignored
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    line(1'b1, 500);
    chk("t3_err", K_ERRCNT, 1);
    send_byte(8'h77, 1'b1);
    line(1'b1, 2100);
    chk("t3_no_frame", K_POPS, 2);
    expect_frame(32'h0000_003C, 3'd1);
    send_byte(8'h3C, 1'b1);
    line(1'b1, 2100);
    drain("t3_drain", 3000);
    chk("t3_pops", K_POPS, 3);

    // 4: short low glitch is a false start
    line(1'b0, 30);
    line(1'b1, 300);
    chk("t4_busy_after_glitch", K_BUSY, 0);
    expect_frame(32'h0000_005A, 3'd1);
    send_byte(8'h5A, 1'b1);
    line(1'b1, 2100);
    drain("t4_drain", 3000);
    chk("t4_err", K_ERRCNT, 1);
    chk("t4_pops", K_POPS, 4);

    // 5: second frame while first is held -> overrun, first frame survives
    ready = 1'b0;
    expect_frame(32'h0000_0001, 3'd1);
    send_byte(8'h01, 1'b1);
    line(1'b1, 2100);
    chk("t5_valid", K_VALID, 1);
    send_byte(8'h02, 1'b1);
    line(1'b1, 2100);
    chk("t5_ovr", K_OVRCNT, 1);
    chk("t5_held_data", K_DATA, 32'h0000_0001);
    chk("t5_held_bytes", K_BYTES, 1);
    cyc(1);
    ready = 1'b1;
    drain("t5_drain", 100);
    chk("t5_valid_clear", K_VALID, 0);
    chk("t5_data_kept", K_DATA, 32'h0000_0001);
    chk("t5_pops", K_POPS, 5);

    // 6: reset mid-byte
    line(1'b0, 500);
    chk("t6_busy", K_BUSY, 1);
    cyc(1);
    rst = 1'b1; sig = 1'b1;
    cyc(1);
    chk("t6_valid", K_VALID, 0); chk("t6_data", K_DATA, 0); chk("t6_bytes", K_BYTES, 0);
    chk("t6_busy0", K_BUSY, 0);  chk("t6_err", K_ERRP, 0);  chk("t6_ovr", K_OVRP, 0);
    cyc(2);
    rst = 1'b0;
    line(1'b1, 2100);
    expect_frame(32'h0000_00C3, 3'd1);
    send_byte(8'hC3, 1'b1);
    line(1'b1, 2100);
    drain("t6_drain", 3000);
    chk("t6_pops", K_POPS, 6);
    chk("final_err", K_ERRCNT, 1);
    chk("final_ovr", K_OVRCNT, 1);
    cyc(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
